instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of instruction decode.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode as packed {instr, pc} with a valid/ready handshake.
- Takes the taken-branch redirect (jump, jaccept, jaddr) from decode, flushes wrong-path state and restarts fetch at the target.

---
 rtl/instr_fetch_unit.sv | 199 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch stage feeding decode. Holds the PC, issues
//                in-order word requests to instruction memory, buffers the
//                returned words in a small queue and presents the head to
//                decode as {instr, pc} under a valid/ready handshake. A taken
//                branch from decode (jump & jaccept) flushes the wrong path
//                and restarts fetch at the word-aligned target.
//
//  Ports       : clk, rst_n            clock, synchronous active-low reset
//                imem_req_*            request channel (valid/ready/addr)
//                imem_resp_*           in-order response channel (valid/data)
//                fetch_valid/ready     decode handshake
//                fetch_instr_pc        {instr[63:32], pc[31:0]} of queue head
//                jump/jaccept/jaddr    redirect from decode
//
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [63:0] fetch_instr_pc,
    input  logic        jump,
    input  logic        jaccept,
    input  logic [31:0] jaddr
);

    localparam int                 c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 c_SUM_W      = CNT_W + 1;
    localparam logic [c_SUM_W-1:0] c_DEPTH      = c_SUM_W'(FIFO_DEPTH);
    // Ceiling on words still owed by memory (discard + outstanding), sized so
    // the discard counter can never wrap even under repeated redirects.
    localparam logic [c_SUM_W:0]   c_FLIGHT_MAX = {1'b0, {c_SUM_W{1'b1}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        r_pc;
    logic               r_run;          // low for one cycle after reset
    logic [CNT_W-1:0]   r_occ;          // filled queue entries
    logic [CNT_W-1:0]   r_out;          // accepted requests awaiting data
    logic [c_SUM_W-1:0] r_disc;         // stale responses still to drop
    logic [c_PTR_W-1:0] r_rd_ptr;       // queue head
    logic [c_PTR_W-1:0] r_fill_ptr;     // slot the next response fills
    logic [c_PTR_W-1:0] r_issue_ptr;    // slot reserved by the next request
    logic [31:0]        r_instr_q [FIFO_DEPTH];
    logic [31:0]        r_pc_q    [FIFO_DEPTH];
    logic [63:0]        r_head;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_redirect;
    logic [31:0]        w_target;
    logic [c_SUM_W-1:0] w_reserved;
    logic [c_SUM_W:0]   w_flight;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic               w_unused;

    assign w_redirect  = jump & jaccept;
    assign w_target    = {jaddr[31:2], 2'b00};
    assign w_unused    = ^jaddr[1:0];
    assign w_reserved  = {1'b0, r_occ} + {1'b0, r_out};
    assign w_flight    = (c_SUM_W + 1)'(r_disc) + (c_SUM_W + 1)'(r_out);
    assign w_req_valid = r_run & ~w_redirect & (w_reserved < c_DEPTH)
                       & (w_flight < c_FLIGHT_MAX);
    assign w_req_fire  = w_req_valid & imem_req_ready;
    assign w_drop      = imem_resp_valid & (r_disc != '0);
    assign w_push      = imem_resp_valid & (r_disc == '0);
    assign w_pop       = (r_occ != '0) & fetch_ready;

    logic [31:0]        w_pc_nxt;
    logic [CNT_W-1:0]   w_occ_nxt;
    logic [CNT_W-1:0]   w_out_nxt;
    logic [c_SUM_W-1:0] w_disc_nxt;
    logic [c_PTR_W-1:0] w_rd_nxt;
    logic [c_PTR_W-1:0] w_fill_nxt;
    logic [c_PTR_W-1:0] w_issue_nxt;
    logic               w_head_upd;
    logic [63:0]        w_head_nxt;

    always_comb begin
        w_pc_nxt    = r_pc;
        w_occ_nxt   = r_occ;
        w_out_nxt   = r_out;
        w_disc_nxt  = r_disc;
        w_rd_nxt    = r_rd_ptr;
        w_fill_nxt  = r_fill_ptr;
        w_issue_nxt = r_issue_ptr;
        if (w_redirect) begin
            // Every word still owed by memory becomes stale; a response
            // arriving this cycle (dropped or not) settles one of them.
            w_pc_nxt    = w_target;
            w_occ_nxt   = '0;
            w_out_nxt   = '0;
            w_disc_nxt  = c_SUM_W'(w_flight - (c_SUM_W + 1)'(imem_resp_valid));
            w_rd_nxt    = '0;
            w_fill_nxt  = '0;
            w_issue_nxt = '0;
        end else begin
            w_occ_nxt = r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
            w_out_nxt = r_out + CNT_W'(w_req_fire) - CNT_W'(w_push);
            if (w_req_fire) begin
                w_pc_nxt    = r_pc + 32'd4;
                w_issue_nxt = r_issue_ptr + c_PTR_W'(1);
            end
            if (w_drop) begin
                w_disc_nxt = r_disc - c_SUM_W'(1);
            end
            if (w_push) begin
                w_fill_nxt = r_fill_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_nxt = r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    // Output register tracks the entry that will be at the head after this
    // edge. When that entry is being written this same cycle (queue empty or
    // draining its last entry) the response data is bypassed in.
    always_comb begin
        w_head_upd = ~w_redirect & (w_occ_nxt != '0);
        if (w_push && (r_fill_ptr == w_rd_nxt)) begin
            w_head_nxt = {imem_resp_data, r_pc_q[r_fill_ptr]};
        end else begin
            w_head_nxt = {r_instr_q[w_rd_nxt], r_pc_q[w_rd_nxt]};
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_run       <= 1'b0;
            r_occ       <= '0;
            r_out       <= '0;
            r_disc      <= '0;
            r_rd_ptr    <= '0;
            r_fill_ptr  <= '0;
            r_issue_ptr <= '0;
            r_head      <= '0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_run       <= 1'b1;
            r_occ       <= w_occ_nxt;
            r_out       <= w_out_nxt;
            r_disc      <= w_disc_nxt;
            r_rd_ptr    <= w_rd_nxt;
            r_fill_ptr  <= w_fill_nxt;
            r_issue_ptr <= w_issue_nxt;
            if (w_head_upd) begin
                r_head <= w_head_nxt;
            end
        end
    end

    // The request PC is stored with its slot at issue; the instruction word
    // joins it when the response arrives.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_req_fire) begin
                r_pc_q[r_issue_ptr] <= r_pc;
            end
            if (w_push && !w_redirect) begin
                r_instr_q[r_fill_ptr] <= imem_resp_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign fetch_valid    = (r_occ != '0);
    assign fetch_instr_pc = r_head;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed self-checking bench for instr_fetch_unit. A small
//                in-order memory model with programmable latency answers
//                requests; delivered entries are checked against the
//                expected program order, plus hand-computed per-cycle values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [63:0] fetch_instr_pc;
    logic        jump;
    logic        jaccept;
    logic [31:0] jaddr;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (4),
        .CNT_W      (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_instr_pc  (fetch_instr_pc),
        .jump            (jump),
        .jaccept         (jaccept),
        .jaddr           (jaddr)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          hs_count = 0;
    int          fv_count = 0;
    logic [31:0] exp_pc   = c_RESET_PC;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    // values sampled mid-cycle, describing the cycle just executed
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_fv;
    logic [63:0] s_fip;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_fv        = fetch_valid;
        s_fip       = fetch_instr_pc;
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + lat);
                hs_count++;
            end
            if (fetch_valid) fv_count++;
            if (fetch_valid && fetch_ready) begin
                check("deliver_pc",    {32'h0, fetch_instr_pc[31:0]},  {32'h0, exp_pc});
                check("deliver_instr", {32'h0, fetch_instr_pc[63:32]}, {32'h0, mem_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            if (jump && jaccept) exp_pc = {jaddr[31:2], 2'b00};
        end
        @(posedge clk);
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
            exp_pc = c_RESET_PC;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Leaves the bench at the start of the first cycle after the reset edge.
    task automatic do_reset();
        rst_n = 1'b0; jump = 1'b0; jaccept = 1'b0; jaddr = '0;
        fetch_ready = 1'b0; imem_req_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; jump = 1'b0; jaccept = 1'b0; jaddr = '0;
        fetch_ready = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0;
        @(negedge clk);

        // ---------------- streaming ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b1; fetch_ready = 1'b1;
        cycle();
        check("rst_req_valid", {63'h0, s_req_valid}, 64'h0);
        check("rst_fetch_valid", {63'h0, s_fv}, 64'h0);
        check("rst_instr_pc", s_fip, 64'h0);
        cycle();
        check("stream_req_valid", {63'h0, s_req_valid}, 64'h1);
        check("stream_addr0", {32'h0, s_req_addr}, 64'h100);
        cycle();
        check("stream_addr1", {32'h0, s_req_addr}, 64'h104);
        check("stream_empty", {63'h0, s_fv}, 64'h0);
        cycle();
        check("stream_e0", s_fip, 64'hDEAD0100_00000100);
        cycle();
        check("stream_e1", s_fip, 64'hDEAD0104_00000104);
        cycle();
        check("stream_e2", s_fip, 64'hDEAD0108_00000108);

        // ---------------- backpressure ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b1; fetch_ready = 1'b0; hs_count = 0;
        repeat (10) cycle();
        check("bp_req_count", 64'(hs_count), 64'd4);
        check("bp_req_valid_full", {63'h0, s_req_valid}, 64'h0);
        check("bp_head_hold", s_fip, 64'hDEAD0100_00000100);
        fetch_ready = 1'b1;
        cycle();
        check("bp_still_full", {63'h0, s_req_valid}, 64'h0);
        cycle();
        check("bp_resume_valid", {63'h0, s_req_valid}, 64'h1);
        check("bp_resume_addr", {32'h0, s_req_addr}, 64'h110);
        repeat (6) cycle();

        // ---------------- redirect with requests in flight ----------------
        do_reset();
        lat = 3; imem_req_ready = 1'b1; fetch_ready = 1'b1;
        repeat (3) cycle();
        jump = 1'b1; jaccept = 1'b1; jaddr = 32'h0000_2003;
        cycle();
        check("rd_no_issue", {63'h0, s_req_valid}, 64'h0);
        jump = 1'b0; jaccept = 1'b0; jaddr = '0; fv_count = 0;
        cycle();
        check("rd_target_valid", {63'h0, s_req_valid}, 64'h1);
        check("rd_target_addr", {32'h0, s_req_addr}, 64'h2000);
        repeat (3) cycle();
        check("rd_stale_dropped", 64'(fv_count), 64'd0);
        cycle();
        check("rd_first_entry", s_fip, 64'hDEAD2000_00002000);
        repeat (4) cycle();

        // ---------------- redirect coincident with a response ----------------
        do_reset();
        lat = 2; imem_req_ready = 1'b1; fetch_ready = 1'b1;
        repeat (3) cycle();
        jump = 1'b1; jaccept = 1'b1; jaddr = 32'h0000_3000;
        cycle();
        check("co_no_issue", {63'h0, s_req_valid}, 64'h0);
        jump = 1'b0; jaccept = 1'b0; jaddr = '0; fv_count = 0;
        repeat (3) cycle();
        check("co_stale_dropped", 64'(fv_count), 64'd0);
        cycle();
        check("co_first_valid", {63'h0, s_fv}, 64'h1);
        check("co_first_entry", s_fip, 64'hDEAD3000_00003000);
        repeat (3) cycle();

        // ---------------- stall at memory ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b0; fetch_ready = 1'b1;
        cycle();
        repeat (5) begin
            cycle();
            check("stall_valid", {63'h0, s_req_valid}, 64'h1);
            check("stall_addr", {32'h0, s_req_addr}, 64'h100);
        end
        imem_req_ready = 1'b1;
        cycle();
        check("stall_go_addr0", {32'h0, s_req_addr}, 64'h100);
        cycle();
        check("stall_go_addr1", {32'h0, s_req_addr}, 64'h104);
        cycle();
        check("stall_e0", s_fip, 64'hDEAD0100_00000100);
        cycle();
        check("stall_e1", s_fip, 64'hDEAD0104_00000104);
        repeat (3) cycle();

        // ---------------- back-to-back redirects ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b1; fetch_ready = 1'b1;
        repeat (5) cycle();
        jump = 1'b1; jaccept = 1'b1; jaddr = 32'h0000_4000;
        cycle();
        jaddr = 32'h0000_5001;
        cycle();
        check("b2b_no_issue", {63'h0, s_req_valid}, 64'h0);
        jump = 1'b0; jaccept = 1'b0; jaddr = '0;
        cycle();
        check("b2b_target_addr", {32'h0, s_req_addr}, 64'h5000);
        cycle();
        cycle();
        check("b2b_first_entry", s_fip, 64'hDEAD5000_00005000);
        repeat (3) cycle();

        // ---------------- reset mid-stream ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b1; fetch_ready = 1'b0;
        repeat (5) cycle();
        rst_n = 1'b0;
        cycle();
        check("mr_queue_held", {63'h0, s_fv}, 64'h1);
        rst_n = 1'b1;
        cycle();
        check("mr_fetch_valid", {63'h0, s_fv}, 64'h0);
        check("mr_req_valid", {63'h0, s_req_valid}, 64'h0);
        check("mr_instr_pc", s_fip, 64'h0);
        fetch_ready = 1'b1;
        cycle();
        check("mr_restart_addr", {32'h0, s_req_addr}, 64'h100);
        cycle();
        cycle();
        check("mr_first_entry", s_fip, 64'hDEAD0100_00000100);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
